// File: rtl/fifo_uart_tx.sv
// UART-style serial transmitter that pops one word per frame from an upstream FIFO
// and shifts it out LSB-first with start, optional parity and stop bits.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_rdata,
  output logic             o_ren,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] STOP_MAX = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             ren;
  logic             wrap;

  function automatic logic parity_bit(input logic [WIDTH-1:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction

  assign wrap = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    ren     = 1'b0;
    o_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Gated by reset so the FIFO is never popped while the block is held in reset.
        ren   = i_en & ~i_empty & ~i_rst;
        cnt_d = '0;
        bit_d = '0;
        if (ren) state_d = S_FETCH;
      end
      S_FETCH: begin
        sh_d    = i_rdata;
        par_d   = parity_bit(i_rdata);
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (wrap) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (wrap) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          if (bit_q == BIT_MAX) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PAR: begin
        cnt_d = cnt_q + CW'(1);
        if (wrap) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (wrap) begin
          cnt_d = '0;
          if (bit_q == STOP_MAX) begin
            o_done  = 1'b1;
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line is registered, so it is driven from the state being entered.
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge i_clk) begin
    sh_q  <= sh_d;
    par_q <= par_d;
  end

  assign o_ren  = ren;
  assign o_tx   = tx_q;
  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds the no-parity instance; two parity
// instances share a one-word feeder. Waveforms are compared per cycle against a frame model.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] rdata0 = 8'h00;
  logic       empty0;
  logic       ren0, tx0, busy0, done0;

  logic       en_p = 1'b0;
  logic       empty_p = 1'b1;
  logic [7:0] rdata_p = 8'h07;
  logic       ren1, tx1, busy1, done1;
  logic       ren2, tx2, busy2, done2;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  int         pass_cnt = 0;
  int         total_cnt = 0;

  logic [9:0] frm [$];

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_empty(empty0), .i_rdata(rdata0),
    .o_ren(ren0), .o_tx(tx0), .o_busy(busy0), .o_done(done0));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_en(en_p), .i_empty(empty_p), .i_rdata(rdata_p),
    .o_ren(ren1), .o_tx(tx1), .o_busy(busy1), .o_done(done1));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (
    .i_clk(clk), .i_rst(rst), .i_en(en_p), .i_empty(empty_p), .i_rdata(rdata_p),
    .o_ren(ren2), .o_tx(tx2), .o_busy(busy2), .o_done(done2));

  // FIFO model: read data appears the cycle after an accepted strobe
  assign empty0 = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (ren0 && (wr_ptr != rd_ptr)) begin
      rdata0 <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic wait_ren(output bit ok);
    int n;
    n = 0;
    #1;
    ok = (ren0 === 1'b1);
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      ok = (ren0 === 1'b1);
    end
  endtask

  // Each frame occupies 42 cycles after its strobe: FETCH, 40 serial cycles, IDLE.
  task automatic check_stream(input string nm, input int drop_at);
    int nf, len, j, r, etx, eren, edone, ebusy;
    int btx, bren, bdone, bbusy;
    bit ok;
    logic [9:0] f;
    nf = frm.size();
    len = 42 * nf;
    btx = 0; bren = 0; bdone = 0; bbusy = 0;
    wait_ren(ok);
    chk({nm, "_ren_seen"}, int'(ok), 1);
    if (ok) begin
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        j = i / 42;
        r = i % 42;
        f = frm[j];
        etx   = (r == 0 || r == 41) ? 1 : int'(f[(r-1)/4]);
        eren  = (r == 41 && j < nf - 1) ? 1 : 0;
        edone = (r == 40) ? 1 : 0;
        ebusy = (r == 41) ? 0 : 1;
        if (int'(tx0) != etx) btx++;
        if (int'(ren0) != eren) bren++;
        if (int'(done0) != edone) bdone++;
        if (int'(busy0) != ebusy) bbusy++;
        if (i == drop_at) en = 1'b0;
      end
      chk({nm, "_tx_bad_cycles"}, btx, 0);
      chk({nm, "_ren_bad_cycles"}, bren, 0);
      chk({nm, "_done_bad_cycles"}, bdone, 0);
      chk({nm, "_busy_bad_cycles"}, bbusy, 0);
    end
    frm.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w0, w1, w2;
    int n, cnt, b1, b2, bd, p1, p2;
    bit ok;
    logic [10:0] f1, f2;

    vecs[0] = '{d: 8'hA5, frame: 10'b1101001010};
    vecs[1] = '{d: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{d: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{d: 8'h3C, frame: 10'b1001111000};

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", int'(tx0), 1);
    chk("rst_ren", int'(ren0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single frames
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(vecs[k].d);
      frm.push_back(vecs[k].frame);
      check_stream($sformatf("vec%0d", k), -1);
    end

    // Back-to-back frames: two idle-high cycles between STOP and next START
    push(8'h00);
    push(8'hFF);
    frm.push_back(model_frame(8'h00));
    frm.push_back(model_frame(8'hFF));
    check_stream("b2b", -1);

    // Random bursts against the frame model
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 3);
      for (int m = 0; m < n; m++) begin
        w0 = 8'($urandom);
        push(w0);
        frm.push_back(model_frame(w0));
      end
      check_stream($sformatf("rnd%0d", k), -1);
    end

    // Parity instances, data 0x07
    f1 = 11'b11000001110;
    f2 = 11'b10000001110;
    @(negedge clk);
    en_p = 1'b1;
    empty_p = 1'b0;
    n = 0;
    #1;
    while (!(ren1 === 1'b1) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("par_ren1_seen", int'(ren1), 1);
    chk("par_ren2_seen", int'(ren2), 1);
    @(posedge clk);
    #1 empty_p = 1'b1;
    b1 = 0; b2 = 0; bd = 0; p1 = -1; p2 = -1;
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      if (i == 37) begin p1 = int'(tx1); p2 = int'(tx2); end
      if (tx1 !== ((i == 0 || i == 45) ? 1'b1 : f1[(i-1)/4])) b1++;
      if (tx2 !== ((i == 0 || i == 45) ? 1'b1 : f2[(i-1)/4])) b2++;
      if (done1 !== (i == 44) || done2 !== (i == 44)) bd++;
      if (busy1 !== (i < 45) || busy2 !== (i < 45)) bd++;
      if (ren1 !== 1'b0 || ren2 !== 1'b0) bd++;
    end
    chk("par_even_bit", p1, 1);
    chk("par_odd_bit", p2, 0);
    chk("par_even_tx_bad_cycles", b1, 0);
    chk("par_odd_tx_bad_cycles", b2, 0);
    chk("par_ctrl_bad_cycles", bd, 0);
    en_p = 1'b0;

    // Enable gating: no strobe while disabled, frame completes after mid-frame drop
    en = 1'b0;
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    push(w0); push(w1); push(w2);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ren0) cnt++;
    end
    chk("en_off_ren_count", cnt, 0);
    chk("en_off_busy", int'(busy0), 0);
    en = 1'b1;
    frm.push_back(model_frame(w0));
    check_stream("en_drop", 8);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ren0) cnt++;
    end
    chk("en_drop_ren_count", cnt, 0);
    chk("en_drop_words_left", wr_ptr - rd_ptr, 2);
    en = 1'b1;
    frm.push_back(model_frame(w1));
    frm.push_back(model_frame(w2));
    check_stream("en_resume", -1);

    // Reset during DATA bit 3 (bit 3 forced low so the async rise is visible)
    w0 = 8'($urandom) & 8'hF7;
    w1 = 8'($urandom);
    push(w0); push(w1);
    wait_ren(ok);
    chk("rst_mid_ren_seen", int'(ok), 1);
    repeat (19) @(negedge clk);
    chk("rst_mid_pre_tx", int'(tx0), 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", int'(tx0), 1);
    chk("rst_mid_busy", int'(busy0), 0);
    chk("rst_mid_ren", int'(ren0), 0);
    chk("rst_mid_done", int'(done0), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_words_left", wr_ptr - rd_ptr, 1);
    frm.push_back(model_frame(w1));
    check_stream("post_rst", -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
